// File: rtl/commit_ctrl.sv
// commit_ctrl: retirement gating for the two oldest ROB entries.
// Decides which slots retire, raises exception/ertn strobes toward the CSR unit,
// and sequences flush + redirect, the post-flush drain and the IDLE wait.
module commit_ctrl #(
    parameter int COMMIT_WIDTH = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int PC_WIDTH     = 32
) (
    input  logic                                   clk,
    input  logic                                   a_rst_n,
    input  logic [COMMIT_WIDTH-1:0]                cmt_valid,
    input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0]  cmt_pc,
    input  logic [COMMIT_WIDTH-1:0]                cmt_excp,
    input  logic [COMMIT_WIDTH-1:0][5:0]           cmt_ecode,
    input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0]  cmt_badv,
    input  logic [COMMIT_WIDTH-1:0]                cmt_br_redirect,
    input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0]  cmt_br_target,
    input  logic [COMMIT_WIDTH-1:0]                cmt_ertn,
    input  logic [COMMIT_WIDTH-1:0]                cmt_refetch,
    input  logic [COMMIT_WIDTH-1:0]                cmt_idle,
    input  logic                                   intr_i,
    input  logic [PC_WIDTH-1:0]                    eentry_i,
    input  logic [PC_WIDTH-1:0]                    era_i,
    output logic [COMMIT_WIDTH-1:0]                retire_en_o,
    output logic                                   excp_commit_o,
    output logic [5:0]                             excp_ecode_o,
    output logic [PC_WIDTH-1:0]                    excp_pc_o,
    output logic [PC_WIDTH-1:0]                    excp_badv_o,
    output logic                                   ertn_commit_o,
    output logic                                   flush_o,
    output logic                                   redirect_valid_o,
    output logic [PC_WIDTH-1:0]                    redirect_pc_o,
    output logic                                   stall_alloc_o
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_FLUSH     = 2'd1,
        S_DRAIN     = 2'd2,
        S_IDLE_WAIT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [PC_WIDTH-1:0]   r_target;
    logic [PC_WIDTH-1:0]   w_target_next;
    logic                  r_to_idle;
    logic                  w_to_idle_next;

    // Per-slot event decode
    logic [COMMIT_WIDTH-1:0]               w_event;
    logic [COMMIT_WIDTH-1:0]               w_slot_idle;
    logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] w_slot_target;

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_slot
            logic [PC_WIDTH-1:0] w_pc_plus4;
            // pc+4 wraps naturally at the width of the address
            assign w_pc_plus4 = cmt_pc[gi] + PC_WIDTH'(4);
            assign w_event[gi] = cmt_valid[gi] & (cmt_excp[gi] | cmt_ertn[gi] |
                                 cmt_br_redirect[gi] | cmt_refetch[gi] | cmt_idle[gi]);
            // Only an idle that is not shadowed by a higher-priority event parks the core
            assign w_slot_idle[gi] = ~cmt_excp[gi] & ~cmt_ertn[gi] & ~cmt_br_redirect[gi] &
                                     ~cmt_refetch[gi] & cmt_idle[gi];
            // Redirect target by in-slot priority: excp > ertn > br > refetch/idle
            assign w_slot_target[gi] = cmt_excp[gi]        ? eentry_i :
                                       cmt_ertn[gi]        ? era_i :
                                       cmt_br_redirect[gi] ? cmt_br_target[gi] :
                                                             w_pc_plus4;
        end
    endgenerate

    logic                    w_intr;
    logic                    w_sel;
    logic [COMMIT_WIDTH-1:0] w_retire_mask;

    // Interrupt only counts when there is an oldest instruction to attach it to
    assign w_intr = intr_i & cmt_valid[0];
    // Oldest slot with an event wins
    assign w_sel  = ~w_event[0];
    // Retire up to the event slot; an excepting slot itself does not retire
    assign w_retire_mask = w_sel ? {~cmt_excp[1], 1'b1} : {1'b0, ~cmt_excp[0]};

    // State, drain counter and saved redirect target
    always_ff @(posedge clk) begin
        if (!a_rst_n) begin
            r_state   <= S_RUN;
            r_cnt     <= 4'd0;
            r_target  <= '0;
            r_to_idle <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_target  <= w_target_next;
            r_to_idle <= w_to_idle_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_target_next    = r_target;
        w_to_idle_next   = r_to_idle;
        retire_en_o      = '0;
        excp_commit_o    = 1'b0;
        excp_ecode_o     = 6'd0;
        excp_pc_o        = '0;
        excp_badv_o      = '0;
        ertn_commit_o    = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        stall_alloc_o    = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_intr) begin
                    excp_commit_o  = 1'b1;
                    excp_pc_o      = cmt_pc[0];
                    w_target_next  = eentry_i;
                    w_to_idle_next = 1'b0;
                    w_state_next   = S_FLUSH;
                end else if (|w_event) begin
                    retire_en_o    = w_retire_mask & cmt_valid;
                    ertn_commit_o  = ~cmt_excp[w_sel] & cmt_ertn[w_sel];
                    if (cmt_excp[w_sel]) begin
                        excp_commit_o = 1'b1;
                        excp_ecode_o  = cmt_ecode[w_sel];
                        excp_pc_o     = cmt_pc[w_sel];
                        excp_badv_o   = cmt_badv[w_sel];
                    end
                    w_target_next  = w_slot_target[w_sel];
                    w_to_idle_next = w_slot_idle[w_sel];
                    w_state_next   = S_FLUSH;
                end else begin
                    retire_en_o = cmt_valid;
                end
            end
            S_FLUSH: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = r_target;
                stall_alloc_o    = 1'b1;
                if (r_to_idle) begin
                    w_state_next = S_IDLE_WAIT;
                end else begin
                    w_state_next = S_DRAIN;
                    w_cnt_next   = 4'(DRAIN_CYCLES);
                end
            end
            S_DRAIN: begin
                stall_alloc_o = 1'b1;
                if (r_cnt <= 4'd1) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = S_RUN;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_IDLE_WAIT: begin
                stall_alloc_o = 1'b1;
                // The saved target of an idle flush is its pc+4, i.e. the era on wake
                if (intr_i) begin
                    excp_commit_o  = 1'b1;
                    excp_pc_o      = r_target;
                    w_target_next  = eentry_i;
                    w_to_idle_next = 1'b0;
                    w_state_next   = S_FLUSH;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Testbench for commit_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the commit rules.
module tb_commit_ctrl;
    localparam int PCW   = 32;
    localparam int DRAIN = 2;

    logic            clk = 1'b0;
    logic            a_rst_n;
    logic [1:0]      cmt_valid, cmt_excp, cmt_br_redirect, cmt_ertn, cmt_refetch, cmt_idle;
    logic [1:0][31:0] cmt_pc, cmt_badv, cmt_br_target;
    logic [1:0][5:0] cmt_ecode;
    logic            intr_i;
    logic [31:0]     eentry_i, era_i;

    logic [1:0]      retire_en_o;
    logic            excp_commit_o, ertn_commit_o, flush_o, redirect_valid_o, stall_alloc_o;
    logic [5:0]      excp_ecode_o;
    logic [31:0]     excp_pc_o, excp_badv_o, redirect_pc_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  retire;
        logic        excp;
        logic [5:0]  ecode;
        logic [31:0] epc;
        logic [31:0] badv;
        logic        ertn;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
    } outs_t;

    outs_t dut_outs;
    assign dut_outs = {retire_en_o, excp_commit_o, excp_ecode_o, excp_pc_o, excp_badv_o,
                       ertn_commit_o, flush_o, redirect_valid_o, redirect_pc_o, stall_alloc_o};

    commit_ctrl #(.COMMIT_WIDTH(2), .DRAIN_CYCLES(DRAIN), .PC_WIDTH(PCW)) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_excp(cmt_excp), .cmt_ecode(cmt_ecode),
        .cmt_badv(cmt_badv), .cmt_br_redirect(cmt_br_redirect), .cmt_br_target(cmt_br_target),
        .cmt_ertn(cmt_ertn), .cmt_refetch(cmt_refetch), .cmt_idle(cmt_idle),
        .intr_i(intr_i), .eentry_i(eentry_i), .era_i(era_i),
        .retire_en_o(retire_en_o), .excp_commit_o(excp_commit_o), .excp_ecode_o(excp_ecode_o),
        .excp_pc_o(excp_pc_o), .excp_badv_o(excp_badv_o), .ertn_commit_o(ertn_commit_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .stall_alloc_o(stall_alloc_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_flush;      // a flush/redirect is owed this cycle
    bit          m_to_idle;    // that flush parks the core
    logic [31:0] m_target;
    int          m_drain;      // stall cycles still owed after a flush
    bit          m_idle;       // parked, waiting for an interrupt
    logic [31:0] m_idle_pc;
    bit          e_fire;       // event seen this cycle (set by model_eval)
    bit          e_idle;
    logic [31:0] e_target;

    function automatic outs_t model_eval();
        outs_t o = '0;
        e_fire = 0; e_idle = 0; e_target = '0;
        if (m_flush) begin
            o.flush = 1; o.redir = 1; o.rpc = m_target; o.stall = 1;
        end else if (m_drain > 0) begin
            o.stall = 1;
        end else if (m_idle) begin
            o.stall = 1;
            if (intr_i) begin
                o.excp = 1; o.epc = m_idle_pc;
                e_fire = 1; e_target = eentry_i;
            end
        end else if (intr_i && cmt_valid[0]) begin
            o.excp = 1; o.epc = cmt_pc[0];
            e_fire = 1; e_target = eentry_i;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!cmt_valid[i]) break;
                if (cmt_excp[i]) begin
                    o.excp = 1; o.ecode = cmt_ecode[i]; o.epc = cmt_pc[i]; o.badv = cmt_badv[i];
                    e_fire = 1; e_target = eentry_i;
                    break;
                end
                o.retire[i] = 1'b1;
                if (cmt_ertn[i]) begin
                    o.ertn = 1; e_fire = 1; e_target = era_i; break;
                end else if (cmt_br_redirect[i]) begin
                    e_fire = 1; e_target = cmt_br_target[i]; break;
                end else if (cmt_refetch[i]) begin
                    e_fire = 1; e_target = cmt_pc[i] + 32'd4; break;
                end else if (cmt_idle[i]) begin
                    e_fire = 1; e_idle = 1; e_target = cmt_pc[i] + 32'd4; break;
                end
            end
        end
        return o;
    endfunction

    function automatic void model_step();
        if (!a_rst_n) begin
            m_flush = 0; m_to_idle = 0; m_target = '0; m_drain = 0; m_idle = 0; m_idle_pc = '0;
        end else if (m_flush) begin
            m_flush = 0;
            if (m_to_idle) begin
                m_idle = 1; m_idle_pc = m_target;
            end else begin
                m_drain = DRAIN;
            end
        end else if (m_drain > 0) begin
            m_drain = m_drain - 1;
        end else if (e_fire) begin
            m_flush = 1; m_target = e_target; m_to_idle = e_idle; m_idle = 0;
        end
    endfunction

    // One clock: sample outputs mid-cycle, evaluate model, then advance both
    task automatic run_cycle(output outs_t got, output outs_t exp);
        @(negedge clk);
        got = dut_outs;
        exp = model_eval();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs(input logic [1:0] valid);
        cmt_valid = valid; cmt_excp = '0; cmt_br_redirect = '0; cmt_ertn = '0;
        cmt_refetch = '0; cmt_idle = '0; intr_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmt_pc[i] = 32'h1c000000 + 32'(i * 4); cmt_ecode[i] = '0;
            cmt_badv[i] = '0; cmt_br_target[i] = '0;
        end
        eentry_i = 32'h1c008000; era_i = 32'h1c00a000;
    endtask

    task automatic settle(input int n, input string name);
        outs_t got, exp;
        clear_inputs(2'b11);
        for (int k = 0; k < n; k++) begin
            run_cycle(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", name, got, exp);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        outs_t got, exp;
        clear_inputs(2'b00);
        a_rst_n = 1'b0;
        repeat (3) begin @(posedge clk); model_step(); #1; end
        a_rst_n = 1'b1;
        run_cycle(got, exp);
        checks++;
        if (got !== '0 || got !== exp) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got, outs_t'('0));
        end
    endtask

    task automatic test_no_events();
        outs_t got, exp;
        clear_inputs(2'b11);
        for (int k = 0; k < 8; k++) begin
            cmt_pc[0] = {$urandom_range(0, 32'h3fffffff), 2'b00};
            cmt_pc[1] = cmt_pc[0] + 32'd4;
            run_cycle(got, exp);
            checks++;
            if (got !== exp || got.retire !== 2'b11 || got.flush !== 1'b0) begin
                failures++;
                $display("FAIL no_events got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_branch();
        outs_t got, exp;
        clear_inputs(2'b11);
        cmt_br_redirect = 2'b01; cmt_br_target[0] = 32'h1c000100;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.retire !== 2'b01 || got.flush !== 1'b0) begin
            failures++;
            $display("FAIL br_commit got=%h exp=%h", got, exp);
        end
        cmt_br_redirect = 2'b00;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.flush !== 1'b1 || got.redir !== 1'b1 || got.rpc !== 32'h1c000100) begin
            failures++;
            $display("FAIL br_flush got=%h exp_rpc=%h", got, 32'h1c000100);
        end
        for (int k = 0; k < DRAIN; k++) begin
            run_cycle(got, exp);
            checks++;
            if (got !== exp || got.stall !== 1'b1 || got.retire !== 2'b00) begin
                failures++;
                $display("FAIL br_drain got=%h exp=%h", got, exp);
            end
        end
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.retire !== 2'b11 || got.stall !== 1'b0) begin
            failures++;
            $display("FAIL br_resume got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_excp_slot1();
        outs_t got, exp;
        clear_inputs(2'b11);
        cmt_excp = 2'b10; cmt_ecode[1] = 6'h09; cmt_badv[1] = 32'h44; cmt_pc[1] = 32'h1c000304;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.retire !== 2'b01 || got.excp !== 1'b1 || got.ecode !== 6'h09 ||
            got.epc !== 32'h1c000304 || got.badv !== 32'h44) begin
            failures++;
            $display("FAIL excp_slot1 got=%h exp=%h", got, exp);
        end
        cmt_excp = 2'b00;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.flush !== 1'b1 || got.rpc !== 32'h1c008000) begin
            failures++;
            $display("FAIL excp_redirect got=%h exp_rpc=%h", got, 32'h1c008000);
        end
        settle(3, "excp_settle");
    endtask

    task automatic test_idle();
        outs_t got, exp;
        clear_inputs(2'b11);
        cmt_idle = 2'b01; cmt_pc[0] = 32'h1c000200;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.retire !== 2'b01) begin
            failures++;
            $display("FAIL idle_commit got=%h exp=%h", got, exp);
        end
        cmt_idle = 2'b00;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.flush !== 1'b1 || got.rpc !== 32'h1c000204) begin
            failures++;
            $display("FAIL idle_flush got=%h exp_rpc=%h", got, 32'h1c000204);
        end
        for (int k = 0; k < 20; k++) begin
            run_cycle(got, exp);
            checks++;
            if (got !== exp || got.stall !== 1'b1 || got.retire !== 2'b00 || got.excp !== 1'b0) begin
                failures++;
                $display("FAIL idle_wait got=%h exp=%h", got, exp);
            end
        end
        intr_i = 1'b1;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.excp !== 1'b1 || got.ecode !== 6'd0 || got.epc !== 32'h1c000204) begin
            failures++;
            $display("FAIL idle_wake got=%h exp=%h", got, exp);
        end
        intr_i = 1'b0;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.flush !== 1'b1 || got.rpc !== 32'h1c008000) begin
            failures++;
            $display("FAIL idle_wake_flush got=%h exp_rpc=%h", got, 32'h1c008000);
        end
        settle(3, "idle_settle");
    endtask

    task automatic test_intr_over_ertn();
        outs_t got, exp;
        clear_inputs(2'b01);
        cmt_ertn = 2'b01; intr_i = 1'b1; cmt_pc[0] = 32'h1c000500;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.retire !== 2'b00 || got.ertn !== 1'b0 || got.excp !== 1'b1 ||
            got.ecode !== 6'd0 || got.epc !== 32'h1c000500) begin
            failures++;
            $display("FAIL intr_ertn got=%h exp=%h", got, exp);
        end
        cmt_ertn = 2'b00; intr_i = 1'b0;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.rpc !== 32'h1c008000 || got.flush !== 1'b1) begin
            failures++;
            $display("FAIL intr_redirect got=%h exp_rpc=%h", got, 32'h1c008000);
        end
        settle(3, "intr_settle");
    endtask

    task automatic test_wrap();
        outs_t got, exp;
        clear_inputs(2'b01);
        cmt_refetch = 2'b01; cmt_pc[0] = 32'hfffffffc;
        run_cycle(got, exp);
        cmt_refetch = 2'b00;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.flush !== 1'b1 || got.rpc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_redirect got=%h exp_rpc=%h", got, 32'h0);
        end
        settle(3, "wrap_settle");
    endtask

    task automatic test_reset_in_drain();
        outs_t got, exp, want;
        clear_inputs(2'b11);
        cmt_br_redirect = 2'b01; cmt_br_target[0] = 32'h1c000700;
        run_cycle(got, exp);
        cmt_br_redirect = 2'b00;
        run_cycle(got, exp);
        a_rst_n = 1'b0;
        run_cycle(got, exp);
        checks++;
        if (got !== exp || got.stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_drain_pre got=%h exp=%h", got, exp);
        end
        a_rst_n = 1'b1;
        run_cycle(got, exp);
        want = '0; want.retire = 2'b11;
        checks++;
        if (got !== want || got !== exp) begin
            failures++;
            $display("FAIL rst_drain_resume got=%h exp=%h", got, want);
        end
    endtask

    task automatic test_random();
        outs_t got, exp;
        int sel;
        for (int k = 0; k < 600; k++) begin
            sel = int'($urandom_range(0, 3));
            cmt_valid = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            for (int i = 0; i < 2; i++) begin
                cmt_pc[i]        = ($urandom_range(0, 15) == 0) ? 32'hfffffffc : {$urandom_range(0, 32'h3fffffff), 2'b00};
                cmt_badv[i]      = $urandom;
                cmt_br_target[i] = {$urandom_range(0, 32'h3fffffff), 2'b00};
                cmt_ecode[i]     = 6'($urandom_range(1, 63));
                cmt_excp[i]        = ($urandom_range(0, 11) == 0);
                cmt_ertn[i]        = ($urandom_range(0, 11) == 0);
                cmt_br_redirect[i] = ($urandom_range(0, 9) == 0);
                cmt_refetch[i]     = ($urandom_range(0, 11) == 0);
                cmt_idle[i]        = ($urandom_range(0, 13) == 0);
            end
            intr_i   = ($urandom_range(0, 15) == 0);
            eentry_i = {$urandom_range(0, 32'h3fffffff), 2'b00};
            era_i    = {$urandom_range(0, 32'h3fffffff), 2'b00};
            a_rst_n  = ($urandom_range(0, 79) != 0);
            run_cycle(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, got, exp);
            end
        end
        a_rst_n = 1'b1;
    endtask

    initial begin
        a_rst_n = 1'b0;
        clear_inputs(2'b00);
        test_reset();
        test_no_events();
        test_branch();
        test_excp_slot1();
        test_idle();
        test_intr_over_ertn();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
